// File: rtl/branch_ctrl.sv
// Branch resolution controller for the EX stage: holds the ALU flag register,
// resolves branches against bypassed flags, and sequences PC redirect and IF/ID flush.
module branch_ctrl #(
    parameter int AW           = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flags_we,
    input  logic [3:0]       flags_in,
    input  logic             br_valid,
    input  logic [2:0]       br_type,
    input  logic [AW-1:0]    br_target,
    output logic             br_ready,
    output logic             pc_load,
    output logic [AW-1:0]    pc_target,
    output logic             flush_if,
    output logic             flush_id,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t           state_r;
    logic [FCW-1:0]   flush_cnt_r;
    logic             pc_load_r;
    logic [AW-1:0]    pc_target_r;
    logic             flush_if_r;
    logic             flush_id_r;
    logic [3:0]       flags_r;
    logic [CNT_W-1:0] br_count_r;
    logic [CNT_W-1:0] taken_count_r;

    logic [3:1]       eff_flags_s;
    logic             cond_s;
    logic             ready_s;
    logic             accept_s;
    logic             taken_s;

    // Condition decode over {GT, EQ, LT}; the carry flag does not steer branches.
    function automatic logic cond_true(input logic [2:0] typ, input logic [3:1] f);
        logic t;
        case (typ)
            3'b000:  t = f[2];
            3'b001:  t = ~f[2];
            3'b010:  t = f[3];
            3'b011:  t = f[1];
            3'b100:  t = f[3] | f[2];
            3'b101:  t = f[1] | f[2];
            3'b110:  t = 1'b1;
            3'b111:  t = 1'b0;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Branch evaluation with same-cycle flag bypass from the ALU.
    always_comb begin
        eff_flags_s = flags_r[3:1];
        if (flags_we) begin
            eff_flags_s = flags_in[3:1];
        end else begin
            eff_flags_s = flags_r[3:1];
        end
        cond_s   = cond_true(br_type, eff_flags_s);
        ready_s  = (state_r == ST_IDLE);
        accept_s = br_valid & ready_s;
        taken_s  = accept_s & cond_s;
    end

    // Redirect/flush sequencer: a taken branch opens a FLUSH_CYCLES-long flush window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            flush_cnt_r <= {FCW{1'b0}};
            pc_load_r   <= 1'b0;
            pc_target_r <= {AW{1'b0}};
            flush_if_r  <= 1'b0;
            flush_id_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (taken_s) begin
                        state_r     <= ST_FLUSH;
                        flush_cnt_r <= FLUSH_LAST;
                        pc_load_r   <= 1'b1;
                        pc_target_r <= br_target;
                        flush_if_r  <= 1'b1;
                        flush_id_r  <= 1'b1;
                    end else begin
                        pc_load_r   <= 1'b0;
                        flush_if_r  <= 1'b0;
                        flush_id_r  <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    pc_load_r <= 1'b0;
                    if (flush_cnt_r == {FCW{1'b0}}) begin
                        state_r    <= ST_IDLE;
                        flush_if_r <= 1'b0;
                        flush_id_r <= 1'b0;
                    end else begin
                        flush_cnt_r <= flush_cnt_r - FCW'(1);
                        flush_if_r  <= 1'b1;
                        flush_id_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    flush_cnt_r <= {FCW{1'b0}};
                    pc_load_r   <= 1'b0;
                    flush_if_r  <= 1'b0;
                    flush_id_r  <= 1'b0;
                end
            endcase
        end
    end

    // Architectural flags load on every ALU write, regardless of flush state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_r <= 4'b0000;
        end else if (flags_we) begin
            flags_r <= flags_in;
        end else begin
            flags_r <= flags_r;
        end
    end

    // Saturating statistics; wrong-path branches during flush never reach accept_s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_r    <= {CNT_W{1'b0}};
            taken_count_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            br_count_r <= sat_inc(br_count_r);
            if (taken_s) begin
                taken_count_r <= sat_inc(taken_count_r);
            end else begin
                taken_count_r <= taken_count_r;
            end
        end else begin
            br_count_r    <= br_count_r;
            taken_count_r <= taken_count_r;
        end
    end

    assign br_ready    = ready_s;
    assign pc_load     = pc_load_r;
    assign pc_target   = pc_target_r;
    assign flush_if    = flush_if_r;
    assign flush_id    = flush_id_r;
    assign flags_q     = flags_r;
    assign br_count    = br_count_r;
    assign taken_count = taken_count_r;

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch resolution controller for the core's EX stage. It holds the architectural ALU flag register and evaluates a conditional or unconditional branch against those flags, forwarding same-cycle flags when present. On a taken branch it issues a one-cycle PC redirect and a multi-cycle IF/ID flush, then returns to accepting branches. It also keeps saturating branch statistics for performance debug.

## Interface
- `AW`, 32, PC/target address width
- `FLUSH_CYCLES`, 2, number of cycles `flush_if`/`flush_id` stay high after a taken branch (≥1)
- `CNT_W`, 16, width of statistics counters
- `clk`  in  1  core clock
- `rst`  in  1  reset, asynchronous, active-high
- `flags_we`  in  1  ALU writes flags this cycle
- `flags_in`  in  4  ALU flags {GT, EQ, LT, C} (bit3..bit0)
- `br_valid`  in  1  branch instruction present in EX
- `br_type`  in  3  condition: 000 EQ, 001 NE, 010 GT, 011 LT, 100 GE, 101 LE, 110 ALWAYS, 111 NEVER
- `br_target`  in  AW  branch destination
- `br_ready`  out  1  controller can accept a branch
- `pc_load`  out  1  one-cycle PC redirect pulse
- `pc_target`  out  AW  redirect address, valid while `pc_load`
- `flush_if`  out  1  squash IF stage
- `flush_id`  out  1  squash ID stage
- `flags_q`  out  4  architectural flag register
- `br_count`  out  CNT_W  accepted branches, saturating
- `taken_count`  out  CNT_W  taken branches, saturating

## Operation
- Condition truth: EQ=F[2]; NE=!F[2]; GT=F[3]; LT=F[1]; GE=F[3]|F[2]; LE=F[1]|F[2]; ALWAYS=1; NEVER=0.
- Effective flags F = `flags_in` when `flags_we`=1, else `flags_q` (same-cycle bypass).
- `flags_q` loads `flags_in` on every `flags_we`, in any state, including FLUSH.
- Accept = `br_valid & br_ready`. Each accept increments `br_count`; each taken accept also increments `taken_count`. Both counters hold at all-ones.
- FSM states:
  - IDLE: `br_ready`=1. A taken accept registers `br_target` and moves to FLUSH with counter = FLUSH_CYCLES-1. A not-taken accept stays in IDLE and has no other effect.
  - FLUSH: `br_ready`=0, `flush_if`=`flush_id`=1. `pc_load`=1 only in the first FLUSH cycle. Counter decrements each cycle; at 0 the FSM returns to IDLE next cycle.
- `br_valid` during FLUSH is a wrong-path instruction: it is ignored, not counted, and does not redirect.
- `pc_target` holds its last registered value when `pc_load`=0.

## Timing
- Reset values: state IDLE, `br_ready`=1, `pc_load`=0, `pc_target`=0, `flush_if`=`flush_id`=0, `flags_q`=0000, both counters 0.
- Asynchronous `rst` mid-FLUSH forces IDLE and all reset values immediately, without waiting for a clock edge.
- Taken accept at edge of cycle T:
  - T+1: `pc_load`=1, `pc_target`=target, flushes high.
  - Flushes stay high through T+FLUSH_CYCLES.
  - `br_ready` returns to 1 at T+FLUSH_CYCLES+1.
- Branch throughput: one per cycle while not taken; a taken branch blocks for FLUSH_CYCLES cycles.
- Counters update on the edge that accepts the branch, so they are visible in T+1.
- All outputs are registered except `br_ready`, which is decoded from state.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> all outputs equal reset values immediately; after release `br_ready`=1 and `flags_q`=0000.
- Bypass EQ taken: `flags_we`=1, `flags_in`=0100, `br_valid`=1, type 000, target 0x100 in the same cycle -> next cycle `pc_load`=1 and `pc_target`=0x100; flushes high for exactly 2 cycles; `flags_q`=0100; `br_count`=1, `taken_count`=1.
- Not taken: `flags_q`=1100, type 001 (NE) -> no `pc_load`, no flush, `br_ready` stays 1; `br_count` increments, `taken_count` unchanged.
- Flush shadow: GE branch with flags 1001 is taken; assert `br_valid` type 110 during both FLUSH cycles -> no second `pc_load`, counters unchanged; `flags_we` with 0010 during FLUSH sets `flags_q`=0010.
- Back-to-back: LT taken with 0010, then an LE branch presented on the first cycle `br_ready`=1 -> second `pc_load` occurs exactly FLUSH_CYCLES+1 cycles after the first; NEVER type is never taken.
- Saturation: set `CNT_W`=2 and issue 5 taken ALWAYS branches -> both counters hold at 3.
